// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared types and arithmetic helpers for the parallel neuron
//
// Purpose: activation and FSM state enums, the beat-count helper, and the
//          saturating add / narrow functions used by the accumulator and
//          output stage. All helpers work on a 64-bit signed carrier, so the
//          neuron supports DATA_WIDTH up to 31.
// Ports:   none (package).
package neuron_pkg;

  typedef enum logic {
    ACT_RELU   = 1'b0,
    ACT_LINEAR = 1'b1
  } act_e;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_BIAS  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  localparam int CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Clamp value into the signed range of a width-bit word; clamped flags a clip.
  function automatic calc_t sat_narrow(input calc_t value, input int width,
                                       output logic clamped);
    calc_t hi;
    calc_t lo;
    hi = (calc_t'(1) <<< (width - 1)) - calc_t'(1);
    lo = -(calc_t'(1) <<< (width - 1));
    clamped = 1'b0;
    if (value > hi) begin
      clamped = 1'b1;
      return hi;
    end
    if (value < lo) begin
      clamped = 1'b1;
      return lo;
    end
    return value;
  endfunction

  // Operands must already lie in the width-bit range; the carrier cannot overflow.
  function automatic calc_t sat_add(input calc_t a, input calc_t b, input int width,
                                    output logic clamped);
    return sat_narrow(a + b, width, clamped);
  endfunction

endpackage

// File: rtl/neuron_weight_rom.sv
// rtl/neuron_weight_rom.sv - per-neuron weight ROM, one LANES-wide word per beat
//
// Purpose: holds ceil(NUM_WEIGHT/LANES) words; word b lane i is weight
//          b*LANES+i. Weights past NUM_WEIGHT read as zero so a partial final
//          beat contributes nothing from its unused lanes. The image is the
//          flattened weight list (weight k at [k*DATA_WIDTH +: DATA_WIDTH]).
// Ports:
//   addr   in   ADDR_W            beat index, read combinationally
//   rdata  out  LANES*DATA_WIDTH  weights for that beat, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
module neuron_weight_rom
  import neuron_pkg::*;
#(
  parameter int NUM_WEIGHT = 784,
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 8,
  parameter logic [NUM_WEIGHT*DATA_WIDTH-1:0] WEIGHT_INIT = '0
) (
  input  logic [ADDR_W-1:0]           addr,
  output logic [LANES*DATA_WIDTH-1:0] rdata
);

  localparam int BEATS  = ceil_div(NUM_WEIGHT, LANES);
  localparam int WORD_W = LANES * DATA_WIDTH;

  // Zero-extension pads the tail of the last word with zero weights.
  localparam logic [BEATS*WORD_W-1:0] IMAGE = (BEATS*WORD_W)'(WEIGHT_INIT);

  logic [WORD_W-1:0] rom_words [BEATS];

  for (genvar b = 0; b < BEATS; b++) begin : g_word
    assign rom_words[b] = IMAGE[b*WORD_W +: WORD_W];
  end

  assign rdata = rom_words[addr];

endmodule

// File: rtl/parallel_neuron.sv
// rtl/parallel_neuron.sv - multi-lane fixed-point neuron with saturating accumulate
//
// Purpose: accepts LANES activations per beat, multiplies by ROM weights,
//          accumulates, adds bias, applies relu/linear, and returns one result
//          per inference over a valid/ready handshake.
// Build option: PARALLEL_NEURON_SAT_EN selects saturating accumulate, bias add
//          and output narrowing with a sticky sat flag; without it all three
//          wrap and sat is tied low.
// Ports:
//   clk        in   1                 clock, rising edge
//   rst_n      in   1                 synchronous active-low reset
//   in_valid   in   1                 beat valid
//   in_ready   out  1                 high while accepting beats
//   in_data    in   LANES*DATA_WIDTH  signed activations, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  out  1                 result valid
//   out_ready  in   1                 result consumed on out_valid & out_ready
//   out_data   out  DATA_WIDTH        activated result, Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS
//   sat        out  1                 a clamp occurred during this inference
// Weights and bias come in as WEIGHT_INIT / BIAS_INIT; LAYER_NO / NEURON_NO
// identify the neuron's slot in the layer array.
module parallel_neuron
  import neuron_pkg::*;
#(
  parameter int    LAYER_NO   = 0,
  parameter int    NEURON_NO  = 0,
  parameter int    NUM_WEIGHT = 784,
  parameter int    LANES      = 4,
  parameter int    DATA_WIDTH = 16,
  parameter int    FRAC_BITS  = 11,
  parameter string ACT_TYPE   = "relu",
  parameter logic [NUM_WEIGHT*DATA_WIDTH-1:0] WEIGHT_INIT = '0,
  parameter logic [DATA_WIDTH-1:0]            BIAS_INIT   = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        sat
);

  localparam int   BEATS     = ceil_div(NUM_WEIGHT, LANES);
  localparam int   CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int   PW        = 2 * DATA_WIDTH;
  localparam act_e ACT       = (ACT_TYPE == "linear") ? ACT_LINEAR : ACT_RELU;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

`ifdef PARALLEL_NEURON_SAT_EN
  localparam int SUM_W = PW + $clog2(LANES);
`else
  // Wrapping arithmetic only ever keeps the low PW bits of the lane sum.
  localparam int SUM_W = PW;
`endif

  // Bias moved onto the product scale (2*FRAC_BITS fractional bits).
  localparam logic signed [PW-1:0] BIAS_AL =
    $signed({{(PW-DATA_WIDTH){BIAS_INIT[DATA_WIDTH-1]}}, BIAS_INIT}) <<< FRAC_BITS;

  state_e                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [LANES-1:0][PW-1:0]   prod_q, prod_d;
  logic                       prod_vld_q, prod_vld_d;
  logic signed [PW-1:0]       acc_q, acc_d;
  logic [DATA_WIDTH-1:0]      out_data_q, out_data_d;
`ifdef PARALLEL_NEURON_SAT_EN
  logic                       sat_q, sat_d;
  logic                       c_acc, c_bias, c_out;
  calc_t                      biased;
`else
  logic signed [PW-1:0]       biased;
`endif

  logic [LANES*DATA_WIDTH-1:0] rom_word;
  logic                        accept;
  logic signed [PW-1:0]        a_ext, w_ext;
  logic signed [SUM_W-1:0]     lane_sum;
  logic [DATA_WIDTH-1:0]       res;

  neuron_weight_rom #(
    .NUM_WEIGHT  (NUM_WEIGHT),
    .LANES       (LANES),
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_W      (CW),
    .WEIGHT_INIT (WEIGHT_INIT)
  ) u_rom (
    .addr  (cnt_q),
    .rdata (rom_word)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    prod_vld_d = 1'b0;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    a_ext      = '0;
    w_ext      = '0;
    lane_sum   = '0;
    biased     = '0;
    res        = '0;
`ifdef PARALLEL_NEURON_SAT_EN
    sat_d      = sat_q;
    c_acc      = 1'b0;
    c_bias     = 1'b0;
    c_out      = 1'b0;
`endif

    accept = (state_q == ST_ACC) && in_valid;

    // Stage 1: multiply the accepted beat; products land on the accepting edge.
    if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        a_ext     = PW'($signed(in_data[i*DATA_WIDTH +: DATA_WIDTH]));
        w_ext     = PW'($signed(rom_word[i*DATA_WIDTH +: DATA_WIDTH]));
        prod_d[i] = a_ext * w_ext;
      end
      prod_vld_d = 1'b1;
    end

    // Stage 2: fold the previous beat's products into the accumulator.
    if (prod_vld_q) begin
      for (int i = 0; i < LANES; i++) begin
        lane_sum = lane_sum + SUM_W'($signed(prod_q[i]));
      end
`ifdef PARALLEL_NEURON_SAT_EN
      acc_d = PW'(sat_add(calc_t'(acc_q), calc_t'(lane_sum), PW, c_acc));
      sat_d = sat_d | c_acc;
`else
      acc_d = acc_q + lane_sum;
`endif
    end

    case (state_q)
      ST_ACC: begin
        if (accept) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        // The final beat's products are consumed the cycle after they land.
        if (!prod_vld_q) state_d = ST_BIAS;
      end
      ST_BIAS: begin
`ifdef PARALLEL_NEURON_SAT_EN
        biased = sat_add(calc_t'(acc_q), calc_t'(BIAS_AL), PW, c_bias);
        res    = DATA_WIDTH'(sat_narrow(biased >>> FRAC_BITS, DATA_WIDTH, c_out));
        sat_d  = sat_d | c_bias | c_out;
`else
        biased = acc_q + BIAS_AL;
        res    = DATA_WIDTH'(biased >>> FRAC_BITS);
`endif
        if (ACT == ACT_RELU && res[DATA_WIDTH-1]) res = '0;
        out_data_d = res;
        state_d    = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_ACC;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef PARALLEL_NEURON_SAT_EN
          sat_d   = 1'b0;
`endif
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_ACC;
      cnt_q      <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      out_data_q <= '0;
`ifdef PARALLEL_NEURON_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
`ifdef PARALLEL_NEURON_SAT_EN
      sat_q      <= sat_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = out_data_q;
`ifdef PARALLEL_NEURON_SAT_EN
  assign sat       = sat_q;
`else
  assign sat       = 1'b0;
`endif

endmodule

// File: tb/tb_parallel_neuron.sv
// tb/tb_parallel_neuron.sv - directed vector bench for parallel_neuron
module tb_parallel_neuron;

  localparam int ND = 4;
  localparam logic [15:0] ONE  = 16'h0800;  // 1.0 in Q5.11
  localparam logic [15:0] HALF = 16'h0400;  // 0.5 in Q5.11

`ifdef PARALLEL_NEURON_SAT_EN
  localparam logic [15:0] BIG_EXP_D = 16'h7FFF;
  localparam logic        BIG_EXP_S = 1'b1;
  localparam logic [15:0] NEG_EXP_D = 16'h8000;
  localparam logic        NEG_EXP_S = 1'b1;
`else
  localparam logic [15:0] BIG_EXP_D = 16'h0300;
  localparam logic        BIG_EXP_S = 1'b0;
  localparam logic [15:0] NEG_EXP_D = 16'h0400;
  localparam logic        NEG_EXP_S = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [ND-1:0] in_valid, in_ready, out_valid, out_ready, sat;
  logic [63:0]   in_data [ND];
  logic [15:0]   out_data [ND];
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // 0: relu, 8 weights of 1.0     1: linear, 8 weights of 1.0
  // 2: relu, 8 weights of 0x7FFF  3: relu, 6 weights of 1.0 (partial last beat)
  parallel_neuron #(.NUM_WEIGHT(8), .LANES(4), .DATA_WIDTH(16), .FRAC_BITS(11),
    .ACT_TYPE("relu"), .WEIGHT_INIT({8{ONE}}), .BIAS_INIT(HALF)) u_relu (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .sat(sat[0]));

  parallel_neuron #(.NUM_WEIGHT(8), .LANES(4), .DATA_WIDTH(16), .FRAC_BITS(11),
    .ACT_TYPE("linear"), .WEIGHT_INIT({8{ONE}}), .BIAS_INIT(HALF)) u_lin (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .sat(sat[1]));

  parallel_neuron #(.NUM_WEIGHT(8), .LANES(4), .DATA_WIDTH(16), .FRAC_BITS(11),
    .ACT_TYPE("relu"), .WEIGHT_INIT({8{16'h7FFF}}), .BIAS_INIT(HALF)) u_big (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .sat(sat[2]));

  parallel_neuron #(.NUM_WEIGHT(6), .LANES(4), .DATA_WIDTH(16), .FRAC_BITS(11),
    .ACT_TYPE("relu"), .WEIGHT_INIT({6{ONE}}), .BIAS_INIT(HALF)) u_six (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(in_data[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_data(out_data[3]), .sat(sat[3]));

  typedef struct {
    int          dut;
    logic [63:0] b0;
    logic [63:0] b1;
    logic [15:0] exp_d;
    logic        exp_s;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int d, input string tag);
    int n;
    n = 0;
    while (!in_ready[d] && n < 20) begin
      step();
      n++;
    end
    check({tag, "_in_ready"}, 32'(in_ready[d]), 32'd1);
  endtask

  // Counts edges from the final-beat acceptance until out_valid; 3 expected.
  task automatic wait_out(input int d, input string tag);
    int lat;
    lat = 0;
    while (!out_valid[d] && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd3);
  endtask

  task automatic handshake(input int d, input string tag);
    out_ready[d] = 1'b1;
    step();
    out_ready[d] = 1'b0;
    check({tag, "_valid_cleared"}, 32'(out_valid[d]), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready[d]), 32'd1);
  endtask

  task automatic run_inf(input int d, input logic [63:0] b0, input logic [63:0] b1,
                         input logic [15:0] exp_d, input logic exp_s, input string tag);
    wait_ready(d, tag);
    in_valid[d] = 1'b1;
    in_data[d]  = b0;
    step();
    in_data[d]  = b1;
    step();
    in_valid[d] = 1'b0;
    in_data[d]  = '1;
    check({tag, "_ready_low"}, 32'(in_ready[d]), 32'd0);
    wait_out(d, tag);
    check({tag, "_data"}, 32'(out_data[d]), 32'(exp_d));
    check({tag, "_sat"}, 32'(sat[d]), 32'(exp_s));
    handshake(d, tag);
  endtask

  initial begin
    logic seen;

    vecs[0]  = '{0, {4{ONE}}, {4{ONE}}, 16'h4400, 1'b0};
    vecs[1]  = '{0, {4{16'hF800}}, {4{16'hF800}}, 16'h0000, 1'b0};
    vecs[2]  = '{1, {4{16'hF800}}, {4{16'hF800}}, 16'hC400, 1'b0};
    vecs[3]  = '{1, {4{16'h8000}}, {4{16'h8000}}, NEG_EXP_D, NEG_EXP_S};
    vecs[4]  = '{1, {4{ONE}}, {4{ONE}}, 16'h4400, 1'b0};
    vecs[5]  = '{2, {4{16'h7FFF}}, {4{16'h7FFF}}, BIG_EXP_D, BIG_EXP_S};
    vecs[6]  = '{2, {4{16'h0001}}, {4{16'h0001}}, 16'h047F, 1'b0};
    vecs[7]  = '{3, {4{ONE}}, {16'h7FFF, 16'h7FFF, ONE, ONE}, 16'h3400, 1'b0};
    vecs[8]  = '{3, {4{ONE}}, {16'h0000, 16'h0000, ONE, ONE}, 16'h3400, 1'b0};
    vecs[9]  = '{0, {16'h0000, 16'hFC00, 16'h0400, 16'h1000},
                    {16'hF000, ONE, ONE, ONE}, 16'h1C00, 1'b0};
    vecs[10] = '{1, {4{16'h0000}}, {4{16'h0000}}, 16'h0400, 1'b0};

    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    for (int d = 0; d < ND; d++) in_data[d] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("reset_in_ready", 32'(in_ready), 32'hF);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_sat", 32'(sat), 32'h0);
    check("reset_out_data", 32'(out_data[0]), 32'h0);

    for (int k = 0; k < 11; k++) begin
      run_inf(vecs[k].dut, vecs[k].b0, vecs[k].b1, vecs[k].exp_d, vecs[k].exp_s,
              $sformatf("vec%0d", k));
    end

    // Output back-pressure with in_valid held high the whole time.
    wait_ready(0, "bp");
    in_valid[0] = 1'b1;
    in_data[0]  = {4{ONE}};
    step();
    step();
    in_data[0]  = {4{16'h7FFF}};
    wait_out(0, "bp");
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("bp_stall%0d_data", c), 32'(out_data[0]), 32'h4400);
      check($sformatf("bp_stall%0d_valid", c), 32'(out_valid[0]), 32'd1);
      check($sformatf("bp_stall%0d_in_ready", c), 32'(in_ready[0]), 32'd0);
    end
    in_data[0]   = {4{ONE}};
    out_ready[0] = 1'b1;
    step();
    out_ready[0] = 1'b0;
    check("bp_ready_after_hs", 32'(in_ready[0]), 32'd1);
    step();
    step();
    in_valid[0] = 1'b0;
    check("bp_next_ready_low", 32'(in_ready[0]), 32'd0);
    wait_out(0, "bp_next");
    check("bp_next_data", 32'(out_data[0]), 32'h4400);
    handshake(0, "bp_next");

    // Reset one cycle after the first beat: the partial sum must vanish.
    in_valid[0] = 1'b1;
    in_data[0]  = {4{ONE}};
    step();
    rst_n       = 1'b0;
    in_valid[0] = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_mid_in_ready", 32'(in_ready[0]), 32'd1);
    check("rst_mid_out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_mid_out_data", 32'(out_data[0]), 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      seen = seen | out_valid[0];
    end
    check("rst_mid_no_emit", 32'(seen), 32'd0);
    run_inf(0, {4{ONE}}, {4{ONE}}, 16'h4400, 1'b0, "rst_after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
